npc_fetch: RTL and testbench

Fetch-side next-PC unit for the pipelined CPU. It owns the F-stage PC register and consumes the D-stage comparator decision (cmp_out) together with the D-stage instruction to redirect fetch on taken branches and jumps. It honours the branch delay slot, the hazard-unit stall, and an instruction-memory ready handshake, and it holds a redirect across memory wait cycles.

---
 rtl/cpu_defs.sv | 27 ++
 rtl/npc_target.sv | 55 +++++
 rtl/npc_fetch.sv | 81 ++++++++
 tb/tb_npc_fetch.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared opcode/funct constants and fetch FSM state for the CPU
package cpu_defs;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [5:0] FN_MOVZ    = 6'b001010;

    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/npc_target.sv
// rtl/npc_target.sv - D-stage redirect decode and target calculation
module npc_target
    import cpu_defs::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc4,
    input  logic [31:0] rs,
    input  logic        cmp_out,
    output logic        redirect,
    output logic [31:0] target
);

    logic [5:0]  op;
    logic [4:0]  rt;
    logic [5:0]  fn;
    logic [31:0] br_target;
    logic [31:0] j_target;

    assign op = instr[31:26];
    assign rt = instr[20:16];
    assign fn = instr[5:0];

    assign br_target = pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    assign j_target  = {pc4[31:28], instr[25:0], 2'b00};

    // movz and all other SPECIAL functs fall through as non-redirects
    always_comb begin
        redirect = 1'b0;
        target   = br_target;
        case (op)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                redirect = cmp_out;
            end
            OP_REGIMM: begin
                if (rt == RT_BLTZ || rt == RT_BGEZ) begin
                    redirect = cmp_out;
                end
            end
            OP_J, OP_JAL: begin
                redirect = 1'b1;
                target   = j_target;
            end
            OP_SPECIAL: begin
                if (fn == FN_JR || fn == FN_JALR) begin
                    redirect = 1'b1;
                    target   = rs;
                end
            end
            default: begin
                redirect = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/npc_fetch.sv
// rtl/npc_fetch.sv - F-stage PC register with branch/jump redirect and memory-wait hold
module npc_fetch
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d_instr,
    input  logic [31:0] d_pc4,
    input  logic [31:0] d_rs,
    input  logic        cmp_out,
    input  logic        stall,
    input  logic        imem_ready,
    output logic [31:0] f_pc,
    output logic [31:0] f_pc4,
    output logic        imem_req,
    output logic        redirect_hold,
    output logic        addr_err
);

    fetch_state_e state;
    logic [31:0]  pend_pc;
    logic         redirect;
    logic [31:0]  target;
    logic         advance;

    npc_target u_target (
        .instr    (d_instr),
        .pc4      (d_pc4),
        .rs       (d_rs),
        .cmp_out  (cmp_out),
        .redirect (redirect),
        .target   (target)
    );

    assign advance       = ~stall & imem_ready;
    assign f_pc4         = f_pc + 32'd4;
    assign imem_req      = reset;
    assign redirect_hold = (state == HOLD);

    // The delay-slot instruction is already in F, so a redirect only replaces the next fetch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            f_pc     <= RESET_PC;
            pend_pc  <= 32'h0;
            addr_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!stall) begin
                        if (redirect) begin
                            if (advance) begin
                                f_pc     <= target;
                                addr_err <= (target[1:0] != 2'b00);
                            end else begin
                                pend_pc <= target;
                                state   <= HOLD;
                            end
                        end else if (advance) begin
                            f_pc     <= f_pc4;
                            addr_err <= (f_pc4[1:0] != 2'b00);
                        end
                    end
                end
                HOLD: begin
                    if (advance) begin
                        f_pc     <= pend_pc;
                        addr_err <= (pend_pc[1:0] != 2'b00);
                        state    <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npc_fetch.sv
// tb/tb_npc_fetch.sv - directed self-checking bench for npc_fetch
module tb_npc_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] d_instr;
    logic [31:0] d_pc4;
    logic [31:0] d_rs;
    logic        cmp_out;
    logic        stall;
    logic        imem_ready;
    logic [31:0] f_pc;
    logic [31:0] f_pc4;
    logic        imem_req;
    logic        redirect_hold;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    npc_fetch #(.RESET_PC(32'h0000_3000)) dut (
        .clk           (clk),
        .reset         (reset),
        .d_instr       (d_instr),
        .d_pc4         (d_pc4),
        .d_rs          (d_rs),
        .cmp_out       (cmp_out),
        .stall         (stall),
        .imem_ready    (imem_ready),
        .f_pc          (f_pc),
        .f_pc4         (f_pc4),
        .imem_req      (imem_req),
        .redirect_hold (redirect_hold),
        .addr_err      (addr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        reset = 1'b0; stall = 1'b0; imem_ready = 1'b1; cmp_out = 1'b0;
        d_instr = 32'h0; d_pc4 = 32'h0; d_rs = 32'h0;
        #12;
        checks++; if (f_pc !== 32'h3000) begin errors++; $display("FAIL reset_f_pc got %h want %h", f_pc, 32'h3000); end
        checks++; if (f_pc4 !== 32'h3004) begin errors++; $display("FAIL reset_f_pc4 got %h want %h", f_pc4, 32'h3004); end
        checks++; if (redirect_hold !== 1'b0 || addr_err !== 1'b0) begin errors++; $display("FAIL reset_flags got hold=%b err=%b want 0 0", redirect_hold, addr_err); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req got %b want 0", imem_req); end
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL run_imem_req got %b want 1", imem_req); end
        exp_pc = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_pc = exp_pc + 32'd4;
            checks++; if (f_pc !== exp_pc || addr_err !== 1'b0) begin errors++; $display("FAIL seq_step%0d got %h err=%b want %h err=0", i, f_pc, addr_err, exp_pc); end
        end
    endtask

    task automatic test_branch();
        d_instr = 32'h1000_FFFF; d_pc4 = 32'h3008; cmp_out = 1'b1;
        tick();
        checks++; if (f_pc !== 32'h3004) begin errors++; $display("FAIL beq_taken got %h want %h", f_pc, 32'h3004); end
        cmp_out = 1'b0;
        tick();
        checks++; if (f_pc !== 32'h3008) begin errors++; $display("FAIL beq_not_taken got %h want %h", f_pc, 32'h3008); end
    endtask

    task automatic test_movz();
        d_instr = 32'h0000_000A; cmp_out = 1'b1;
        tick();
        checks++; if (f_pc !== 32'h300C) begin errors++; $display("FAIL movz_no_redirect got %h want %h", f_pc, 32'h300C); end
    endtask

    task automatic test_stall();
        d_instr = 32'h1400_003C; d_pc4 = 32'h3010; cmp_out = 1'b1; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (f_pc !== 32'h300C || redirect_hold !== 1'b0) begin errors++; $display("FAIL stall_hold%0d got %h hold=%b want %h hold=0", i, f_pc, redirect_hold, 32'h300C); end
        end
        stall = 1'b0;
        tick();
        checks++; if (f_pc !== 32'h3100) begin errors++; $display("FAIL bne_after_stall got %h want %h", f_pc, 32'h3100); end
    endtask

    task automatic test_hold();
        d_instr = 32'h0C00_0040; d_pc4 = 32'h3104; cmp_out = 1'b0; imem_ready = 1'b0;
        tick();
        checks++; if (f_pc !== 32'h3100 || redirect_hold !== 1'b1) begin errors++; $display("FAIL jal_enter_hold got %h hold=%b want %h hold=1", f_pc, redirect_hold, 32'h3100); end
        // a jr in D while holding must be ignored
        d_instr = 32'h0000_0008; d_rs = 32'h0000_5000;
        for (int i = 0; i < 3; i++) begin
            stall = (i == 1);
            tick();
            checks++; if (f_pc !== 32'h3100 || redirect_hold !== 1'b1) begin errors++; $display("FAIL hold_wait%0d got %h hold=%b want %h hold=1", i, f_pc, redirect_hold, 32'h3100); end
        end
        stall = 1'b0; imem_ready = 1'b1;
        tick();
        checks++; if (f_pc !== 32'h0000_0100 || redirect_hold !== 1'b0) begin errors++; $display("FAIL hold_release got %h hold=%b want %h hold=0", f_pc, redirect_hold, 32'h100); end
        d_instr = 32'h0;
        tick();
        checks++; if (f_pc !== 32'h0000_0104) begin errors++; $display("FAIL after_hold_seq got %h want %h", f_pc, 32'h104); end
    endtask

    task automatic test_reset_in_hold();
        d_instr = 32'h0C00_0040; d_pc4 = 32'h0000_0108; imem_ready = 1'b0;
        tick();
        checks++; if (redirect_hold !== 1'b1) begin errors++; $display("FAIL rih_enter got hold=%b want 1", redirect_hold); end
        reset = 1'b0;
        #2;
        checks++; if (f_pc !== 32'h3000 || redirect_hold !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rih_async got %h hold=%b req=%b want %h 0 0", f_pc, redirect_hold, imem_req, 32'h3000); end
        tick();
        reset = 1'b1; imem_ready = 1'b1; d_instr = 32'h0;
        tick();
        checks++; if (f_pc !== 32'h3004 || redirect_hold !== 1'b0) begin errors++; $display("FAIL rih_resume got %h hold=%b want %h hold=0", f_pc, redirect_hold, 32'h3004); end
    endtask

    task automatic test_jr();
        d_instr = 32'h0000_0008; d_rs = 32'h0000_3102;
        tick();
        checks++; if (f_pc !== 32'h3102 || addr_err !== 1'b1) begin errors++; $display("FAIL jr_target got %h err=%b want %h err=1", f_pc, addr_err, 32'h3102); end
        d_instr = 32'h0;
        tick();
        checks++; if (f_pc !== 32'h3106 || addr_err !== 1'b1) begin errors++; $display("FAIL jr_next got %h err=%b want %h err=1", f_pc, addr_err, 32'h3106); end
    endtask

    task automatic test_wrap();
        d_instr = 32'h0000_0009; d_rs = 32'hFFFF_FFFC;
        tick();
        checks++; if (f_pc !== 32'hFFFF_FFFC || f_pc4 !== 32'h0 || addr_err !== 1'b0) begin errors++; $display("FAIL jalr_top got %h pc4=%h err=%b want fffffffc 0 0", f_pc, f_pc4, addr_err); end
        d_instr = 32'h0;
        tick();
        checks++; if (f_pc !== 32'h0) begin errors++; $display("FAIL pc_wrap got %h want 0", f_pc); end
    endtask

    task automatic test_regimm_j();
        d_instr = 32'h0401_0004; d_pc4 = 32'h0000_0004; cmp_out = 1'b1;
        tick();
        checks++; if (f_pc !== 32'h0000_0014) begin errors++; $display("FAIL bgez_taken got %h want %h", f_pc, 32'h14); end
        d_instr = 32'h0402_0004;
        tick();
        checks++; if (f_pc !== 32'h0000_0018) begin errors++; $display("FAIL regimm_other got %h want %h", f_pc, 32'h18); end
        d_instr = 32'h0800_0800; d_pc4 = 32'h1000_0000; cmp_out = 1'b0;
        tick();
        checks++; if (f_pc !== 32'h1000_2000) begin errors++; $display("FAIL j_target got %h want %h", f_pc, 32'h10002000); end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_movz();
        test_stall();
        test_hold();
        test_reset_in_hold();
        test_jr();
        test_wrap();
        test_regimm_j();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
